fire_bias_relu: RTL
===================

Name: fire_bias_relu

Overview:
- Post-accumulation stage for the fire-module expand layers; sits directly downstream of the per-layer biasing ROM and the MAC array.
- Takes a channel-ordered stream of two's-complement accumulator results and adds the per-channel sign-magnitude bias from the ROM's 128-entry bias bus.
- Applies ReLU, rounds and right-shifts to 16 bits, saturates, and emits a valid/ready stream toward the activation buffer.

Parameters:
- NUM_CH, 128: channels per pixel; channel counter wraps at NUM_CH-1.
- ACC_W, 32: accumulator input width, two's complement.
- BIAS_SHIFT, 0: left shift applied to the bias to align it with the accumulator fixed point (0..ACC_W-17).
- OUT_SHIFT, 0: right shift from the accumulator scale to the output scale (0..ACC_W-16), with round-half-up.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bias_mem  in  16 x [0:NUM_CH-1]  unpacked bias array from the biasing ROM; bit15 = sign, bits14:0 = magnitude.
- sof  in  1  start of pixel; forces the channel counter to 0 for the beat accepted in the same cycle.
- in_valid  in  1  accumulator beat valid.
- in_ready  out  1  stage can accept a beat.
- acc_in  in  ACC_W  accumulator value, two's complement.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  16  result; bit15 is always 0.
- out_ch  out  7  channel index of out_data, width clog2(NUM_CH).
- out_last  out  1  out_ch == NUM_CH-1.

Behaviour:
- Reset (async assert): out_valid=0, out_data=0, out_ch=0, out_last=0, channel counter=0, both pipeline valids=0. in_ready=1 from the first cycle after reset.
- Handshake and stall:
  - A beat is accepted when in_valid && in_ready.
  - stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, both stages hold their data and valid; out_data/out_ch/out_last are stable.
  - No combinational path from in_valid to out_valid.
- Latency: exactly 2 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 beat per cycle.
- Channel counter ch: the accepted beat uses ch = sof ? 0 : ch_reg. After acceptance, ch_reg = (ch == NUM_CH-1) ? 0 : ch+1. sof without in_valid has no effect.
- Stage 1 (register):
  - bias_tc = sign ? -{0,mag} : {0,mag}, sign-extended to ACC_W+1 bits. 16'h8000 (negative zero) equals 0.
  - sum1 = sext(acc_in) + (bias_tc << BIAS_SHIFT), held at ACC_W+1 bits, so no overflow is possible.
  - Register sum1 and ch.
- Stage 2 (register):
  - If sum1 < 0, the result is 0 (ReLU).
  - Otherwise q = (sum1 + (OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0)) >> OUT_SHIFT.
  - If q > 32767, out_data = 16'h7FFF and the beat is flagged saturated; otherwise out_data = q[15:0].
- Output metadata: out_ch and out_last travel alongside the data through both stages.
- Bias sampling: bias_mem is read combinationally at stage 1 and treated as static for the duration of a layer.
- Simultaneous sof and wrap: sof wins; the beat gets ch = 0.
- Reset mid-stream: in-flight beats are discarded and the counter returns to 0; there is no partial output.

Optional Feature:
- Macro: FIRE_BIAS_SAT_CNT_EN.
- When defined:
  - Adds output port sat_cnt (16 bits), reset to 0.
  - sat_cnt increments by 1 on each output handshake whose beat saturated, and holds at 16'hFFFF.
  - Adds input sat_clr (1 bit), a synchronous clear; clear has priority over increment in the same cycle.
- When undefined: neither port exists and there is no counter logic; the datapath is otherwise identical.

Test Plan:
- Basic add and ReLU: BIAS_SHIFT=0, OUT_SHIFT=0, bias[0]=16'h0115, bias[1]=16'h8019. Drive sof=1 with acc=100, then acc=10, out_ready=1 → out_data 377 (ch 0) two cycles after the first beat, then 0 (ch 1; 10-25<0).
- Saturation: ch 0 with acc=40000 → out_data=16'h7FFF. With FIRE_BIAS_SAT_CNT_EN, sat_cnt goes 0→1; asserting sat_clr in the same cycle as a saturating handshake leaves sat_cnt=0.
- Rounding: OUT_SHIFT=2, bias[0]=277, acc=4 → 281 → (281+2)>>2 = 70. Negative zero bias 16'h8000 with acc=5 → 1 (5+2)>>2.
- Wrap: 128 consecutive beats with sof only on the first → out_ch runs 0..127, out_last=1 only on ch 127, and the 129th beat is ch 0. Asserting sof on beat 50 restarts it at ch 0.
- Backpressure: stream 8 beats with out_ready low for 3 cycles after the first output → in_ready low during the stall, outputs held stable, no beat lost or duplicated, order preserved.
- Async reset mid-stream: assert rst between clock edges with 2 beats in flight → out_valid=0 immediately. After release, the next accepted beat is ch 0 with no stale output.

Source files
------------

// File: rtl/fire_bias_relu.sv
// fire_bias_relu
// Post-accumulation stage for the fire-module expand layers. It adds a
// per-channel sign-magnitude bias to each two's-complement accumulator beat,
// then applies ReLU, a round-half-up right shift and saturation to 15 bits.
// The result leaves on a valid/ready stream toward the activation buffer.
//
// The pipeline has two register stages with one shared stall:
//   stage 1 : bias add          -> r_sum1, r_ch1, r_last1, r_v1
//   stage 2 : relu/round/sat    -> out_data, out_ch, out_last, out_valid
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   bias_mem   per-channel bias words from the ROM (bit15 sign, 14:0 magnitude)
//   sof        start of pixel; the beat accepted in the same cycle gets channel 0
//   in_valid   accumulator beat valid
//   in_ready   stage can accept a beat
//   acc_in     accumulator value, two's complement
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   result; bit15 is always 0
//   out_ch     channel index of out_data
//   out_last   out_ch is the last channel of the pixel
//   sat_clr    synchronous clear of sat_cnt      (FIRE_BIAS_SAT_CNT_EN only)
//   sat_cnt    count of saturated output beats   (FIRE_BIAS_SAT_CNT_EN only)
//
// Optional feature: define FIRE_BIAS_SAT_CNT_EN to add the saturation counter.
// The counter sticks at 16'hFFFF, and sat_clr wins over an increment.
module fire_bias_relu #(
   parameter int NUM_CH     = 128,
   parameter int ACC_W      = 32,
   parameter int BIAS_SHIFT = 0,
   parameter int OUT_SHIFT  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [15:0]               bias_mem [0:NUM_CH-1],
   input  logic                      sof,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ACC_W-1:0]          acc_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [15:0]               out_data,
   output logic [$clog2(NUM_CH)-1:0] out_ch,
`ifdef FIRE_BIAS_SAT_CNT_EN
   input  logic                      sat_clr,
   output logic [15:0]               sat_cnt,
`endif
   output logic                      out_last
);

   localparam int CH_W = $clog2(NUM_CH);
   // The sum is one bit wider than the accumulator, so the bias add cannot
   // overflow. The rounding add needs one more bit again.
   localparam int SW = ACC_W + 1;
   localparam int QW = ACC_W + 2;
   localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic [QW-1:0] RND = (OUT_SHIFT > 0) ? (QW'(1) << RND_SH) : '0;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   logic            w_stall;
   logic [CH_W-1:0] r_ch;
   logic [CH_W-1:0] w_ch;
   logic [CH_W-1:0] w_ch_nxt;
   logic [15:0]     w_bias;
   logic [SW-1:0]   w_bias_tc;
   logic [SW-1:0]   w_acc_ext;
   logic [SW-1:0]   w_sum1;

   logic            r_v1;
   logic [SW-1:0]   r_sum1;
   logic [CH_W-1:0] r_ch1;
   logic            r_last1;

   logic            w_neg;
   logic [QW-1:0]   w_q;
   logic            w_sat;
   logic [15:0]     w_dat;

   // The whole pipeline stalls together. Stage 1 cannot drain into a held
   // stage 2, so a global stall keeps the handshake free of bubbles and of
   // any in_valid -> out_valid combinational path.
   assign w_stall  = out_valid && !out_ready;
   assign in_ready = !w_stall;

   assign w_ch     = sof ? '0 : r_ch;
   assign w_ch_nxt = (w_ch == LAST_CH) ? '0 : w_ch + CH_W'(1);

   // Stage 1: convert sign-magnitude to two's complement. Negative zero
   // becomes 0 naturally, because 0 - 0 = 0.
   assign w_bias    = bias_mem[w_ch];
   assign w_bias_tc = w_bias[15] ? (SW'(0) - SW'(w_bias[14:0])) : SW'(w_bias[14:0]);
   assign w_acc_ext = {acc_in[ACC_W-1], acc_in};
   assign w_sum1    = w_acc_ext + (w_bias_tc << BIAS_SHIFT);

   // Stage 2: the shift is only meaningful for non-negative sums, so the
   // zero-extended value is safe to use here.
   assign w_neg = r_sum1[SW-1];
   assign w_q   = ({1'b0, r_sum1} + RND) >> OUT_SHIFT;
   assign w_sat = !w_neg && (w_q > QW'(32767));

   always_comb begin
      w_dat = '0;
      if (w_neg) begin
         w_dat = '0;
      end else if (w_sat) begin
         w_dat = 16'h7FFF;
      end else begin
         w_dat = w_q[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch      <= '0;
         r_v1      <= 1'b0;
         r_sum1    <= '0;
         r_ch1     <= '0;
         r_last1   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else if (!w_stall) begin
         // When the pipe is not stalled, in_ready is high, so in_valid alone
         // means a beat is accepted.
         r_v1 <= in_valid;
         if (in_valid) begin
            r_ch    <= w_ch_nxt;
            r_sum1  <= w_sum1;
            r_ch1   <= w_ch;
            r_last1 <= (w_ch == LAST_CH);
         end
         out_valid <= r_v1;
         if (r_v1) begin
            out_data <= w_dat;
            out_ch   <= r_ch1;
            out_last <= r_last1;
         end
      end
   end

`ifdef FIRE_BIAS_SAT_CNT_EN
   logic r_sat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (!w_stall && r_v1) begin
         r_sat <= w_sat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (sat_clr) begin
         sat_cnt <= '0;
      end else if (out_valid && out_ready && r_sat && (sat_cnt != 16'hFFFF)) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
`endif

endmodule
